// File: rtl/wb_defs.sv
// Shared Wishbone B3 encodings used by the burst RAM and the PCI bridge burst engine.
package wb_defs;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    localparam logic [1:0] BTE_LINEAR = 2'b00;
    localparam logic [1:0] BTE_WRAP4  = 2'b01;
    localparam logic [1:0] BTE_WRAP8  = 2'b10;
    localparam logic [1:0] BTE_WRAP16 = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SINGLE = 2'd1,
        ST_BURST  = 2'd2
    } wb_state_e;

    function automatic logic cti_valid(input logic [2:0] cti);
        return (cti == CTI_CLASSIC) || (cti == CTI_INCR) || (cti == CTI_EOB);
    endfunction

endpackage

// File: rtl/wb_burst_addr.sv
// Next beat address for Wishbone incrementing bursts; wrap modes only move the low bits.
module wb_burst_addr
    import wb_defs::*;
#(
    parameter int ADDRESS = 10
) (
    input  logic [ADDRESS-1:0] adr_i,
    input  logic [1:0]         bte_i,
    output logic [ADDRESS-1:0] next_o
);

    // upper bits are held for the wrap modes
    always_comb begin
        next_o = adr_i;
        case (bte_i)
            BTE_LINEAR: next_o      = adr_i + {{(ADDRESS-1){1'b0}}, 1'b1};
            BTE_WRAP4:  next_o[1:0] = adr_i[1:0] + 2'd1;
            BTE_WRAP8:  next_o[2:0] = adr_i[2:0] + 3'd1;
            BTE_WRAP16: next_o[3:0] = adr_i[3:0] + 4'd1;
            default:    next_o      = adr_i;
        endcase
    end

endmodule

// File: rtl/wb_burst_ram.sv
// Wishbone B3 slave RAM with byte-lane writes and registered-feedback CTI/BTE bursts.
module wb_burst_ram
    import wb_defs::*;
#(
    parameter int ADDRESS = 10,
    parameter bit HIGHZ   = 1'b0
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic               wb_cyc_i,
    input  logic               wb_stb_i,
    input  logic               wb_we_i,
    input  logic [2:0]         wb_cti_i,
    input  logic [1:0]         wb_bte_i,
    input  logic [ADDRESS-1:0] wb_adr_i,
    input  logic [3:0]         wb_sel_i,
    input  logic [31:0]        wb_dat_i,
    output logic               wb_ack_o,
    output logic               wb_err_o,
    output logic               wb_rty_o,
    output logic [31:0]        wb_dat_o,
    output logic [3:0]         wb_sel_o
);

    localparam int DEPTH = 1 << ADDRESS;

    wb_state_e          state_q, state_d;
    logic [ADDRESS-1:0] addr_q, addr_d;
    logic               err_q, err_d;
    logic [31:0]        mem_q [DEPTH];
    logic [31:0]        rdata_q;

    logic               req_s;
    logic               beat_ok_s;
    logic               ack_s;
    logic               err_s;
    logic               wr_en_s;
    logic [ADDRESS-1:0] rd_adr_s;
    logic [ADDRESS-1:0] next_adr_s;
    logic [3:0]         sel_s;

    assign req_s     = wb_cyc_i & wb_stb_i;
    // addr_q is the beat whose data sits in rdata_q; a beat is taken only if the master agrees
    assign beat_ok_s = (state_q == ST_BURST) & req_s & (wb_adr_i == addr_q);

    wb_burst_addr #(.ADDRESS(ADDRESS)) u_next (
        .adr_i  (addr_q),
        .bte_i  (wb_bte_i),
        .next_o (next_adr_s)
    );

    // state register
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= ST_IDLE;
            addr_q  <= {ADDRESS{1'b0}};
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            err_q   <= err_d;
        end
    end

    // next-state logic
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (req_s) begin
                    addr_d  = wb_adr_i;
                    err_d   = ~cti_valid(wb_cti_i);
                    state_d = (wb_cti_i == CTI_INCR) ? ST_BURST : ST_SINGLE;
                end else begin
                    err_d   = 1'b0;
                end
            end
            ST_SINGLE: begin
                state_d = ST_IDLE;
                err_d   = 1'b0;
            end
            ST_BURST: begin
                if (!wb_cyc_i) begin
                    state_d = ST_IDLE;
                end else if (beat_ok_s) begin
                    addr_d = next_adr_s;
                    if (wb_cti_i != CTI_INCR) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_BURST;
                    end
                end else if (wb_stb_i) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_BURST;
                end
            end
            default: begin
                state_d = ST_IDLE;
                err_d   = 1'b0;
            end
        endcase
    end

    // output and RAM-port decode
    always_comb begin
        ack_s    = 1'b0;
        err_s    = 1'b0;
        wr_en_s  = 1'b0;
        rd_adr_s = addr_q;
        case (state_q)
            ST_IDLE: begin
                rd_adr_s = wb_adr_i;
            end
            ST_SINGLE: begin
                ack_s   = ~err_q;
                err_s   = err_q;
                wr_en_s = ~err_q & wb_we_i & req_s;
            end
            ST_BURST: begin
                ack_s   = beat_ok_s;
                wr_en_s = beat_ok_s & wb_we_i;
                if (beat_ok_s) begin
                    rd_adr_s = next_adr_s;
                end else begin
                    rd_adr_s = addr_q;
                end
            end
            default: begin
                rd_adr_s = addr_q;
            end
        endcase
    end

    // byte-lane write plus registered read; a same-edge write is not visible to the read
    always_ff @(posedge wb_clk_i) begin
        for (int b = 0; b < 4; b++) begin
            if (wr_en_s && !wb_rst_i && wb_sel_i[b]) begin
                mem_q[addr_q][8*b +: 8] <= wb_dat_i[8*b +: 8];
            end
        end
        rdata_q <= mem_q[rd_adr_s];
    end

    assign sel_s    = (ack_s & ~wb_we_i) ? 4'hf : 4'h0;
    assign wb_ack_o = ack_s;
    assign wb_err_o = err_s;
    assign wb_rty_o = 1'b0;

    generate
        if (HIGHZ) begin : g_highz
            assign wb_dat_o = ack_s ? rdata_q : {32{1'bz}};
            assign wb_sel_o = ack_s ? sel_s : {4{1'bz}};
        end else begin : g_driven
            assign wb_dat_o = ack_s ? rdata_q : 32'h0000_0000;
            assign wb_sel_o = sel_s;
        end
    endgenerate

endmodule

// File: tb/tb_wb_burst_ram.sv
// Scenario bench for wb_burst_ram: a bench-side memory model feeds an expected-read queue.
module tb_wb_burst_ram;
    import wb_defs::*;

    logic        clk = 1'b0;
    logic        wb_rst_i;
    logic        wb_cyc_i, wb_stb_i, wb_we_i;
    logic [2:0]  wb_cti_i;
    logic [1:0]  wb_bte_i;
    logic [9:0]  wb_adr_i;
    logic [3:0]  wb_sel_i;
    logic [31:0] wb_dat_i;
    logic        wb_ack_o, wb_err_o, wb_rty_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;

    always #5 clk = ~clk;

    wb_burst_ram #(.ADDRESS(10), .HIGHZ(1'b0)) dut (
        .wb_clk_i (clk),      .wb_rst_i (wb_rst_i),
        .wb_cyc_i (wb_cyc_i), .wb_stb_i (wb_stb_i), .wb_we_i (wb_we_i),
        .wb_cti_i (wb_cti_i), .wb_bte_i (wb_bte_i), .wb_adr_i (wb_adr_i),
        .wb_sel_i (wb_sel_i), .wb_dat_i (wb_dat_i),
        .wb_ack_o (wb_ack_o), .wb_err_o (wb_err_o), .wb_rty_o (wb_rty_o),
        .wb_dat_o (wb_dat_o), .wb_sel_o (wb_sel_o)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] model_mem [1024];
    logic [31:0] exp_q [$];
    logic [31:0] obs_q [$];
    logic [9:0]  beat_adr [16];
    logic [31:0] beat_dat [16];

    task automatic bus_idle();
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        wb_cti_i = 3'b000; wb_bte_i = 2'b00; wb_adr_i = 10'h000;
        wb_sel_i = 4'h0; wb_dat_i = 32'h0000_0000;
    endtask

    // Drives one single-beat access and reports what the slave did; callers judge it.
    task automatic classic_xfer(input logic we, input logic [9:0] adr, input logic [31:0] dat,
                                input logic [3:0] sel, input logic [2:0] cti,
                                output int lat, output logic got_ack, output logic got_err,
                                output logic [31:0] got_dat, output logic [3:0] got_sel,
                                output logic ack_after);
        logic found;
        found = 1'b0; lat = -1; got_ack = 1'b0; got_err = 1'b0;
        got_dat = 32'h0000_0000; got_sel = 4'h0;
        @(posedge clk); #1;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we; wb_adr_i = adr;
        wb_dat_i = dat; wb_sel_i = sel; wb_cti_i = cti; wb_bte_i = BTE_LINEAR;
        for (int t = 0; t < 8 && !found; t++) begin
            @(negedge clk);
            if (wb_ack_o || wb_err_o) begin
                found = 1'b1; lat = t; got_ack = wb_ack_o; got_err = wb_err_o;
                got_dat = wb_dat_o; got_sel = wb_sel_o;
            end
            @(posedge clk); #1;
        end
        bus_idle();
        @(negedge clk);
        ack_after = wb_ack_o | wb_err_o;
    endtask

    // Registered-feedback burst master over beat_adr/beat_dat; stall_after and rst_beat < 0 disable.
    task automatic burst_xfer(input logic we, input logic [1:0] bte, input int n,
                              input int stall_after, input int rst_beat,
                              output int acks, output int first_lat, output int span,
                              output logic stall_ack, output logic ack_after);
        int   i, t, tlast;
        logic stalled, in_rst;
        i = 0; t = 0; tlast = -1; acks = 0; first_lat = -1; span = 0;
        stall_ack = 1'b0; stalled = 1'b0; in_rst = 1'b0;
        @(posedge clk); #1;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we; wb_bte_i = bte; wb_sel_i = 4'hf;
        wb_adr_i = beat_adr[0]; wb_dat_i = beat_dat[0];
        wb_cti_i = (n == 1) ? CTI_EOB : CTI_INCR;
        while (i < n && t < 64 && !in_rst) begin
            @(negedge clk);
            if (wb_ack_o) begin
                if (!we) obs_q.push_back(wb_dat_o);
                if (acks == 0) first_lat = t;
                tlast = t; acks++; i++;
                if (i == rst_beat) begin
                    wb_rst_i = 1'b1; in_rst = 1'b1;
                end
            end
            t++;
            @(posedge clk); #1;
            if (in_rst) begin
                wb_rst_i = 1'b0;
            end else if (i < n) begin
                if (i == stall_after && !stalled) begin
                    stalled = 1'b1; wb_stb_i = 1'b0;
                    @(negedge clk);
                    stall_ack = wb_ack_o; t++;
                    @(posedge clk); #1;
                    wb_stb_i = 1'b1;
                end
                wb_adr_i = beat_adr[i]; wb_dat_i = beat_dat[i];
                wb_cti_i = (i == n - 1) ? CTI_EOB : CTI_INCR;
            end
        end
        bus_idle();
        span = (acks > 0) ? (tlast - first_lat + 1) : 0;
        @(negedge clk);
        ack_after = wb_ack_o;
    endtask

    task automatic test_reset();
        wb_rst_i = 1'b1;
        bus_idle();
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_tests++; if (wb_ack_o !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b want 0", wb_ack_o); end
        n_tests++; if (wb_err_o !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", wb_err_o); end
        n_tests++; if (wb_rty_o !== 1'b0) begin n_fail++; $display("FAIL reset_rty: got %b want 0", wb_rty_o); end
        n_tests++; if (wb_dat_o !== 32'h0) begin n_fail++; $display("FAIL reset_dat: got %h want 0", wb_dat_o); end
        n_tests++; if (wb_sel_o !== 4'h0) begin n_fail++; $display("FAIL reset_sel: got %h want 0", wb_sel_o); end
        @(posedge clk); #1;
        wb_rst_i = 1'b0;
    endtask

    task automatic test_classic();
        int lat; logic ak, er, aa; logic [31:0] d, e; logic [3:0] s;
        classic_xfer(1'b1, 10'h005, 32'hdeadbeef, 4'hf, CTI_CLASSIC, lat, ak, er, d, s, aa);
        model_mem[10'h005] = 32'hdeadbeef;
        n_tests++; if (lat !== 1) begin n_fail++; $display("FAIL classic_wr_lat: got %0d want 1", lat); end
        n_tests++; if (ak !== 1'b1 || er !== 1'b0) begin n_fail++; $display("FAIL classic_wr_ack: ack %b err %b want 1 0", ak, er); end
        n_tests++; if (aa !== 1'b0) begin n_fail++; $display("FAIL classic_wr_single: ack after %b want 0", aa); end
        exp_q.push_back(model_mem[10'h005]);
        classic_xfer(1'b0, 10'h005, 32'h0, 4'h0, CTI_EOB, lat, ak, er, d, s, aa);
        e = exp_q.pop_front();
        n_tests++; if (lat !== 1) begin n_fail++; $display("FAIL classic_rd_lat: got %0d want 1", lat); end
        n_tests++; if (d !== e) begin n_fail++; $display("FAIL classic_rd_dat: got %h want %h", d, e); end
        n_tests++; if (s !== 4'hf) begin n_fail++; $display("FAIL classic_rd_sel: got %h want f", s); end
    endtask

    task automatic test_byte_lanes();
        int lat; logic ak, er, aa; logic [31:0] d, e; logic [3:0] s;
        classic_xfer(1'b1, 10'h040, 32'hffffffff, 4'hf, CTI_CLASSIC, lat, ak, er, d, s, aa);
        classic_xfer(1'b1, 10'h040, 32'h11223344, 4'b0101, CTI_CLASSIC, lat, ak, er, d, s, aa);
        model_mem[10'h040] = 32'hff22ff44;
        exp_q.push_back(model_mem[10'h040]);
        classic_xfer(1'b0, 10'h040, 32'h0, 4'h0, CTI_CLASSIC, lat, ak, er, d, s, aa);
        e = exp_q.pop_front();
        n_tests++; if (d !== e || ak !== 1'b1) begin n_fail++; $display("FAIL byte_lanes: got %h ack %b want %h", d, ak, e); end
    endtask

    task automatic test_linear_burst();
        int acks, fl, sp; logic sa, aa; logic [31:0] o, e;
        beat_adr[0] = 10'h3fe; beat_adr[1] = 10'h3ff; beat_adr[2] = 10'h000; beat_adr[3] = 10'h001;
        for (int k = 0; k < 4; k++) beat_dat[k] = 32'(k + 1);
        burst_xfer(1'b1, BTE_LINEAR, 4, -1, -1, acks, fl, sp, sa, aa);
        for (int k = 0; k < 4; k++) model_mem[beat_adr[k]] = beat_dat[k];
        n_tests++; if (acks !== 4 || fl !== 1 || sp !== 4) begin n_fail++; $display("FAIL lin_wr_timing: acks %0d first %0d span %0d want 4 1 4", acks, fl, sp); end
        n_tests++; if (aa !== 1'b0) begin n_fail++; $display("FAIL lin_wr_end: ack after %b want 0", aa); end
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back(model_mem[beat_adr[k]]);
            beat_dat[k] = 32'h0;
        end
        burst_xfer(1'b0, BTE_LINEAR, 4, -1, -1, acks, fl, sp, sa, aa);
        n_tests++; if (acks !== 4 || fl !== 1 || sp !== 4 || aa !== 1'b0) begin n_fail++; $display("FAIL lin_rd_timing: acks %0d first %0d span %0d after %b want 4 1 4 0", acks, fl, sp, aa); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            n_tests++; if (o !== e) begin n_fail++; $display("FAIL lin_rd_dat: got %h want %h", o, e); end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_wrap4_stall();
        int acks, fl, sp; logic sa, aa; logic [31:0] o, e;
        for (int k = 0; k < 4; k++) begin
            beat_adr[k] = 10'(12 + k);
            beat_dat[k] = 32'hc0de_0000 | 32'(12 + k);
        end
        burst_xfer(1'b1, BTE_LINEAR, 4, -1, -1, acks, fl, sp, sa, aa);
        for (int k = 0; k < 4; k++) model_mem[beat_adr[k]] = beat_dat[k];
        n_tests++; if (acks !== 4) begin n_fail++; $display("FAIL wrap_prefill: acks %0d want 4", acks); end
        beat_adr[0] = 10'h00e; beat_adr[1] = 10'h00f; beat_adr[2] = 10'h00c; beat_adr[3] = 10'h00d;
        for (int k = 0; k < 4; k++) exp_q.push_back(model_mem[beat_adr[k]]);
        burst_xfer(1'b0, BTE_WRAP4, 4, 2, -1, acks, fl, sp, sa, aa);
        n_tests++; if (sa !== 1'b0) begin n_fail++; $display("FAIL wrap_stall_ack: got %b want 0", sa); end
        n_tests++; if (acks !== 4 || fl !== 1 || sp !== 5) begin n_fail++; $display("FAIL wrap_timing: acks %0d first %0d span %0d want 4 1 5", acks, fl, sp); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            n_tests++; if (o !== e) begin n_fail++; $display("FAIL wrap_rd_dat: got %h want %h", o, e); end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_err();
        int lat; logic ak, er, aa; logic [31:0] d, e; logic [3:0] s;
        classic_xfer(1'b1, 10'h010, 32'h0badf00d, 4'hf, CTI_CLASSIC, lat, ak, er, d, s, aa);
        model_mem[10'h010] = 32'h0badf00d;
        classic_xfer(1'b1, 10'h010, 32'h12345678, 4'hf, 3'b101, lat, ak, er, d, s, aa);
        n_tests++; if (er !== 1'b1 || ak !== 1'b0 || lat !== 1) begin n_fail++; $display("FAIL err_term: err %b ack %b lat %0d want 1 0 1", er, ak, lat); end
        n_tests++; if (aa !== 1'b0) begin n_fail++; $display("FAIL err_one_cycle: after %b want 0", aa); end
        exp_q.push_back(model_mem[10'h010]);
        classic_xfer(1'b0, 10'h010, 32'h0, 4'h0, CTI_CLASSIC, lat, ak, er, d, s, aa);
        e = exp_q.pop_front();
        n_tests++; if (d !== e) begin n_fail++; $display("FAIL err_no_write: got %h want %h", d, e); end
    endtask

    task automatic test_reset_mid_burst();
        int acks, fl, sp, lat; logic sa, aa, ak, er; logic [31:0] d, e; logic [3:0] s;
        classic_xfer(1'b1, 10'h022, 32'h5555aaaa, 4'hf, CTI_CLASSIC, lat, ak, er, d, s, aa);
        model_mem[10'h022] = 32'h5555aaaa;
        for (int k = 0; k < 8; k++) begin
            beat_adr[k] = 10'(32 + k);
            beat_dat[k] = 32'(8'ha0 + k);
        end
        burst_xfer(1'b1, BTE_LINEAR, 8, -1, 3, acks, fl, sp, sa, aa);
        model_mem[10'h020] = beat_dat[0];
        model_mem[10'h021] = beat_dat[1];
        n_tests++; if (acks !== 3) begin n_fail++; $display("FAIL rst_burst_acks: got %0d want 3", acks); end
        n_tests++; if (aa !== 1'b0) begin n_fail++; $display("FAIL rst_burst_ack_after: got %b want 0", aa); end
        exp_q.push_back(model_mem[10'h022]);
        classic_xfer(1'b0, 10'h022, 32'h0, 4'h0, CTI_CLASSIC, lat, ak, er, d, s, aa);
        e = exp_q.pop_front();
        n_tests++; if (lat !== 1 || d !== e) begin n_fail++; $display("FAIL rst_beat3_dropped: lat %0d got %h want 1 %h", lat, d, e); end
        exp_q.push_back(model_mem[10'h021]);
        classic_xfer(1'b0, 10'h021, 32'h0, 4'h0, CTI_CLASSIC, lat, ak, er, d, s, aa);
        e = exp_q.pop_front();
        n_tests++; if (d !== e) begin n_fail++; $display("FAIL rst_beat2_kept: got %h want %h", d, e); end
    endtask

    initial begin
        bus_idle();
        wb_rst_i = 1'b1;
        test_reset();
        test_classic();
        test_byte_lanes();
        test_linear_burst();
        test_wrap4_stall();
        test_err();
        test_reset_mid_burst();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/wb_burst_ram.md
# wb_burst_ram

Wishbone B3 slave memory that terminates the downstream side of the PCI memory-space bridge: 2^ADDRESS 32-bit words with byte-lane writes. It supports registered-feedback incrementing bursts (CTI/BTE), so PCI burst transfers forwarded by the bridge complete at one word per clock. It replaces the single-beat block RAM behind the bridge in the PCI target path.

## Interface
Parameters:
- ADDRESS, 10, word-address width; depth 2^ADDRESS words (default 4 kB).
- HIGHZ, 0, 1: wb_dat_o/wb_sel_o go to z whenever wb_ack_o is low; 0: always driven.

Ports (one clock; reset is synchronous and active-high):
- wb_clk_i  in  1  Wishbone clock, all logic on the rising edge.
- wb_rst_i  in  1  synchronous active-high reset.
- wb_cyc_i / wb_stb_i / wb_we_i  in  1 each  Wishbone cycle, strobe, write enable.
- wb_cti_i  in  3  cycle type: 000 classic, 010 incrementing burst, 111 end of burst.
- wb_bte_i  in  2  burst type: 00 linear, 01 wrap4, 10 wrap8, 11 wrap16.
- wb_adr_i  in  ADDRESS  word address.
- wb_sel_i  in  4  byte lane enables for writes.
- wb_dat_i  in  32  write data.
- wb_ack_o  out  1  normal termination.
- wb_err_o  out  1  error termination.
- wb_rty_o  out  1  tied 0.
- wb_dat_o  out  32  read data, valid while wb_ack_o is high.
- wb_sel_o  out  4  4'hf during a read ack, otherwise 4'h0.

## Operation
- The FSM has three states: IDLE, SINGLE and BURST. Reset puts it in IDLE with ack_o=0, err_o=0, dat_o=0 (or z when HIGHZ=1), sel_o=0. Memory contents are not cleared.
- IDLE, when cyc&stb is high:
  - cti_i in {000, 111}: read the word at adr_i, latch adr_i, go to SINGLE.
  - cti_i = 010: same as above, then go to BURST with next = inc(adr_i, bte_i).
  - Reserved cti_i (001, 011-110): assert err_o next cycle, go to SINGLE, perform no write.
- SINGLE: ack_o (or err_o) is high for exactly one cycle. A write commits dat_i under sel_i to the latched address in this cycle. The FSM then returns to IDLE, which forces at least one idle cycle between classic accesses.
- BURST: ack_o is high in every cycle where cyc&stb is high and adr_i == the registered expected address.
  - Each acked beat writes (when we_i is set) at that address. The RAM read address advances to inc(address, bte_i) so the next beat's data is ready on the next clock.
  - stb low: ack_o drops, the address holds, the FSM stays in BURST.
  - Acked beat with cti_i=111, cyc low, or adr_i mismatch: ack_o is low next cycle and the FSM goes to IDLE. On a mismatch the current beat is not acked; IDLE then restarts it as a new access.
- inc(a, bte): linear increments a+1 modulo 2^ADDRESS. Wrap4/8/16 increment only the low 2/3/4 bits modulo 4/8/16; the upper bits are held.
- Simultaneous read and write to the same word within a burst: read-before-write (old data is returned).
- wb_rst_i asserted mid-burst: the next cycle has ack_o=0 and the FSM is in IDLE. A beat committing in the reset cycle is discarded.

## Timing
- Classic access: stb at cycle N, ack at N+1. The master drops stb at N+2, and the next access may start at N+2.
- Burst of k beats: first ack at N+1, then one ack per cycle. The last ack is at N+k with no stalls, with ack low at N+k+1.
- Read data and write commit are both aligned to the ack cycle. dat_i and sel_i are sampled on the edge that ends the ack cycle.
- err_o is never high in the same cycle as ack_o.

## Structure
- A shared package wb_defs holds the CTI_CLASSIC/CTI_INCR/CTI_EOB constants and the BTE_LINEAR/WRAP4/WRAP8/WRAP16 encodings, reused by the PCI bridge.
- One sub-module, wb_burst_addr: a combinational next-address calculator (address, bte -> next address), shared with the bridge's burst engine.
- The memory array is inferred with four byte-wide write enables and a registered read port.

## Test plan
- Classic write 32'hdeadbeef to address 0x005 with sel=4'hf, then classic read of 0x005 -> ack one cycle after stb each time, dat_o=32'hdeadbeef, sel_o=4'hf.
- Byte lanes: write 32'h11223344 with sel=4'b0101 over a word holding 32'hffffffff -> readback 32'hff22ff44.
- Linear 4-beat write burst from 0x3fe (writing 1,2,3,4, cti 010,010,010,111), then read burst -> data 1,2,3,4 at 0x3fe, 0x3ff, 0x000, 0x001; acks on 4 consecutive cycles.
- Wrap4 read burst from 0x00e -> addresses 0x00e, 0x00f, 0x00c, 0x00d. A stb-low stall after beat 2 drops ack for that cycle, and the burst resumes with beat 3.
- cti_i=3'b101 write to 0x010 -> err_o high for one cycle, ack_o low, word 0x010 unchanged.
- Reset asserted during beat 3 of an 8-beat write burst -> ack_o=0 the next cycle, beat 3 not written, a classic read immediately afterwards succeeds.
